// File: rtl/ibex_pkg.sv
// Shared constants and types for the CFI call/return detector.
// Build macro IBEX_CFI_X5_LINK_EN adds x5 as a second link register.
package ibex_pkg;

    localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR = 7'b1100111;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    typedef enum logic {
        CFI_IDLE,
        CFI_SWAP_PUSH
    } cfi_state_e;

    typedef enum logic [1:0] {
        CFI_NONE,
        CFI_PUSH,
        CFI_POP,
        CFI_SWAP
    } cfi_op_e;

    function automatic logic is_link(input logic [4:0] r);
`ifdef IBEX_CFI_X5_LINK_EN
        return (r == REG_RA) || (r == REG_T0);
`else
        return (r == REG_RA);
`endif
    endfunction

endpackage

// File: rtl/ibex_cfi_link_decode.sv
// Classifies a retiring instruction as none/push/pop/swap.
// Link set depends on IBEX_CFI_X5_LINK_EN via ibex_pkg::is_link.
module ibex_cfi_link_decode (
    input  logic [31:0]            instr,
    output ibex_pkg::cfi_op_e      op
);
    import ibex_pkg::*;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       is_jal;
    logic       is_jalr;
    logic       link_rd;
    logic       link_rs1;
    logic       unused_imm;

    assign opcode     = instr[6:0];
    assign rd         = instr[11:7];
    assign funct3     = instr[14:12];
    assign rs1        = instr[19:15];
    assign unused_imm = ^instr[31:20];

    assign is_jal   = (opcode == OPCODE_JAL);
    assign is_jalr  = (opcode == OPCODE_JALR) && (funct3 == 3'b000);
    assign link_rd  = is_link(rd);
    assign link_rs1 = is_link(rs1);

    always_comb begin
        op = CFI_NONE;
        unique case (1'b1)
            is_jal: begin
                if (link_rd) op = CFI_PUSH;
            end
            is_jalr: begin
                if (link_rd && !link_rs1) op = CFI_PUSH;
                else if (!link_rd && link_rs1) op = CFI_POP;
                else if (link_rd && link_rs1) begin
                    op = (rd == rs1) ? CFI_PUSH : CFI_SWAP;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ibex_cfi_call_ret_detect.sv
// Detects calls/returns at retirement and drives shadow-stack push/pop.
// IBEX_CFI_X5_LINK_EN enables x5 linking and coroutine-swap sequencing.
module ibex_cfi_call_ret_detect (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    input  logic        instr_is_compressed_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] jump_target_i,
    output logic        push_o,
    output logic [31:0] push_addr_o,
    output logic        pop_o,
    output logic [31:0] pop_addr_o,
    input  logic        ss_error_i,
    input  logic        alert_clr_i,
    output logic        cfi_alert_o
);
    import ibex_pkg::*;

    cfi_state_e  state_q, state_d;
    cfi_op_e     op;
    logic        accept;
    logic [31:0] ret_addr;
    logic [31:0] ret_q, ret_d;
    logic        push_d, pop_d;
    logic [31:0] push_addr_d, pop_addr_d;
    logic        alert_d;

    ibex_cfi_link_decode u_decode (
        .instr (instr_i),
        .op    (op)
    );

`ifdef IBEX_CFI_X5_LINK_EN
    assign instr_ready_o = (state_q == CFI_IDLE);
`else
    assign instr_ready_o = 1'b1;
`endif

    assign accept   = instr_valid_i && instr_ready_o;
    assign ret_addr = pc_i + (instr_is_compressed_i ? 32'd2 : 32'd4);

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        push_addr_d = '0;
        pop_addr_d  = '0;
        case (state_q)
            CFI_IDLE: begin
                if (accept) begin
                    case (op)
                        CFI_PUSH: begin
                            push_d      = 1'b1;
                            push_addr_d = ret_addr;
                        end
                        CFI_POP: begin
                            pop_d      = 1'b1;
                            pop_addr_d = jump_target_i;
                        end
                        CFI_SWAP: begin
`ifdef IBEX_CFI_X5_LINK_EN
                            pop_d      = 1'b1;
                            pop_addr_d = jump_target_i;
                            ret_d      = ret_addr;
                            state_d    = CFI_SWAP_PUSH;
`else
                            push_d      = 1'b1;
                            push_addr_d = ret_addr;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            // pop goes out this cycle; queue the held return address
            CFI_SWAP_PUSH: begin
                push_d      = 1'b1;
                push_addr_d = ret_q;
                state_d     = CFI_IDLE;
            end
            default: state_d = CFI_IDLE;
        endcase
    end

    // a fresh error outranks a clear in the same cycle
    assign alert_d = (ss_error_i && (push_o || pop_o)) ? 1'b1 :
                     alert_clr_i                        ? 1'b0 :
                                                          cfi_alert_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= CFI_IDLE;
            ret_q       <= '0;
            push_o      <= 1'b0;
            pop_o       <= 1'b0;
            push_addr_o <= '0;
            pop_addr_o  <= '0;
            cfi_alert_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            push_o      <= push_d;
            pop_o       <= pop_d;
            push_addr_o <= push_addr_d;
            pop_addr_o  <= pop_addr_d;
            cfi_alert_o <= alert_d;
        end
    end

endmodule

// File: tb/tb_ibex_cfi_call_ret_detect.sv
// Scoreboard bench for ibex_cfi_call_ret_detect (either macro setting).
// Expected push/pop events are queued at issue; a negedge monitor checks.
module tb_ibex_cfi_call_ret_detect;

    typedef struct packed {
        logic        is_push;
        logic [31:0] addr;
    } exp_t;

`ifdef IBEX_CFI_X5_LINK_EN
    localparam bit X5 = 1'b1;
`else
    localparam bit X5 = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] instr_i = '0;
    logic        instr_is_compressed_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] jump_target_i = '0;
    logic        push_o;
    logic [31:0] push_addr_o;
    logic        pop_o;
    logic [31:0] pop_addr_o;
    logic        ss_error_i = 1'b0;
    logic        alert_clr_i = 1'b0;
    logic        cfi_alert_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    ibex_cfi_call_ret_detect dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .instr_valid_i         (instr_valid_i),
        .instr_ready_o         (instr_ready_o),
        .instr_i               (instr_i),
        .instr_is_compressed_i (instr_is_compressed_i),
        .pc_i                  (pc_i),
        .jump_target_i         (jump_target_i),
        .push_o                (push_o),
        .push_addr_o           (push_addr_o),
        .pop_o                 (pop_o),
        .pop_addr_o            (pop_addr_o),
        .ss_error_i            (ss_error_i),
        .alert_clr_i           (alert_clr_i),
        .cfi_alert_o           (cfi_alert_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (push_o && pop_o) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap: got push=1 pop=1 expected one");
            end else if (push_o || pop_o) begin
                exp_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got push=%0b pop=%0b expected none",
                             push_o, pop_o);
                end else begin
                    e = exp_q.pop_front();
                    if (push_o !== e.is_push) begin
                        errors++;
                        $display("FAIL strobe_kind: got push=%0b expected push=%0b",
                                 push_o, e.is_push);
                    end else if ((push_o ? push_addr_o : pop_addr_o) !== e.addr) begin
                        errors++;
                        $display("FAIL strobe_addr: got %h expected %h",
                                 push_o ? push_addr_o : pop_addr_o, e.addr);
                    end
                end
                check("idle_addr", push_o ? pop_addr_o : push_addr_o, 32'h0);
            end else begin
                check("addr_zero", push_addr_o | pop_addr_o, 32'h0);
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic c,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic err, input logic clr);
        int n;
        @(posedge clk_i);
        #1;
        instr_valid_i         = 1'b1;
        instr_i               = ins;
        instr_is_compressed_i = c;
        pc_i                  = pc;
        jump_target_i         = tgt;
        n = 0;
        while (!instr_ready_o && n < 10) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (n == 10) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
        end
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
        ss_error_i    = err;
        alert_clr_i   = clr;
        @(posedge clk_i);
        #1;
        ss_error_i  = 1'b0;
        alert_clr_i = 1'b0;
    endtask

    initial begin
        int n;
        #12;
        check("rst_push", {31'b0, push_o}, 32'h0);
        check("rst_pop", {31'b0, pop_o}, 32'h0);
        check("rst_paddr", push_addr_o, 32'h0);
        check("rst_oaddr", pop_addr_o, 32'h0);
        check("rst_alert", {31'b0, cfi_alert_o}, 32'h0);
        check("rst_ready", {31'b0, instr_ready_o}, 32'h1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // JAL x1, pc 0x100
        exp_q.push_back('{1'b1, 32'h104});
        issue(32'h000000EF, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
        // C.JALR x10 expanded
        exp_q.push_back('{1'b1, 32'h202});
        issue(32'h000500E7, 1'b1, 32'h200, 32'h0, 1'b0, 1'b0);
        // ret with error
        exp_q.push_back('{1'b0, 32'h104});
        issue(32'h00008067, 1'b0, 32'h180, 32'h104, 1'b1, 1'b0);
        check("alert_set", {31'b0, cfi_alert_o}, 32'h1);
        // clear and error together
        exp_q.push_back('{1'b1, 32'h044});
        issue(32'h000000EF, 1'b0, 32'h040, 32'h0, 1'b1, 1'b1);
        check("alert_prio", {31'b0, cfi_alert_o}, 32'h1);
        @(posedge clk_i);
        #1;
        alert_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        alert_clr_i = 1'b0;
        check("alert_clr", {31'b0, cfi_alert_o}, 32'h0);

        // wrap cases
        exp_q.push_back('{1'b1, 32'h0});
        issue(32'h000000EF, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b0);
        exp_q.push_back('{1'b1, 32'h2});
        issue(32'h000000EF, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0);
        exp_q.push_back('{1'b1, 32'h0});
        issue(32'h000000EF, 1'b1, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0);

        // error with no strobe is ignored
        @(posedge clk_i);
        #1;
        ss_error_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        ss_error_i = 1'b0;
        check("no_strobe_err", {31'b0, cfi_alert_o}, 32'h0);

        // no-action encodings: ADDI, JALR funct3=001, JAL x0
        issue(32'h00108093, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0);
        issue(32'h000090E7, 1'b0, 32'h404, 32'h0, 1'b0, 1'b0);
        issue(32'h0000006F, 1'b0, 32'h408, 32'h0, 1'b0, 1'b0);
        // JALR x1,0(x1): push only
        exp_q.push_back('{1'b1, 32'h504});
        issue(32'h000080E7, 1'b0, 32'h500, 32'h600, 1'b0, 1'b0);
        // JAL x5
`ifdef IBEX_CFI_X5_LINK_EN
        exp_q.push_back('{1'b1, 32'h604});
`endif
        issue(32'h000002EF, 1'b0, 32'h600, 32'h0, 1'b0, 1'b0);

        // swap JALR x1,0(x5)
`ifdef IBEX_CFI_X5_LINK_EN
        exp_q.push_back('{1'b0, 32'h500});
`endif
        exp_q.push_back('{1'b1, 32'h304});
        @(posedge clk_i);
        #1;
        instr_valid_i         = 1'b1;
        instr_i               = 32'h000280E7;
        instr_is_compressed_i = 1'b0;
        pc_i                  = 32'h300;
        jump_target_i         = 32'h500;
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
        check("swap_ready", {31'b0, instr_ready_o}, {31'b0, !X5});
        @(posedge clk_i);
        #1;
        check("swap_ready2", {31'b0, instr_ready_o}, 32'h1);
        repeat (3) @(posedge clk_i);

        // reset in SWAP_PUSH drops the push
`ifdef IBEX_CFI_X5_LINK_EN
        exp_q.push_back('{1'b0, 32'h500});
`else
        exp_q.push_back('{1'b1, 32'h304});
`endif
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("rst2_out", {push_addr_o | pop_addr_o},
              32'h0);
        check("rst2_strb", {29'b0, push_o, pop_o, cfi_alert_o}, 32'h0);
        check("rst2_ready", {31'b0, instr_ready_o}, 32'h1);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk_i);
            n++;
        end
        check("queue_empty", exp_q.size(), 32'h0);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
